sisc_ctrl_ws: RTL
=================

// Module: sisc_ctrl_ws
// PURPOSE
//  Multicycle SISC control FSM with memory wait-state handshake, generalised branch conditions,
//  a sticky memory-timeout error and a clean HALT state (no simulator $stop).
//  Sits between IR/status register and datapath (PC, RF, ALU, IR, data memory); drop-in successor
//  of the fixed-latency control unit, with identical datapath strobe semantics.
// PARAMETERS
//  OPW       4   opcode / mm field width
//  CCW       4   status CC width (stat[0] = Z)
//  ALUW      4   alu_op width
//  WAIT_MAX  15  max cycles to wait for mem_rdy before timeout (1..2^8-1; counter 8 bits)
// PORTS
//  clk       in   1     clock, rising edge
//  rst_f     in   1     reset, asynchronous, active-low
//  opcode    in   OPW   IR opcode: NOOP=0 REG_OP=1 REG_IM=2 BRA=4 BRR=5 BNE=6 BNR=7 LDA=10 LDX=11 STA=12 STX=13 HLT=15
//  mm        in   OPW   IR condition mask
//  stat      in   CCW   status register CCs
//  mem_rdy   in   1     memory completes current request this cycle
//  rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, mem_we, rb_sel  out 1  datapath strobes
//  alu_op    out  ALUW  ALU function
//  mem_req   out  1     memory access request (instruction in FETCH, data in MEM)
//  halted    out  1     FSM in HALT
//  mem_err   out  1     sticky: memory timeout occurred
//  state     out  4     present state encoding (debug)
// BEHAVIOUR
//  States: START=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WRITEBACK=5 HALT=6 IDLE=7; others -> START.
//  Reset: state=START, wait_cnt=0, mem_err=0; strobes are combinational decode of state.
//   In START: pc_rst=pc_write=1, all else 0. START -> FETCH next cycle.
//  All strobes default 0 in every state; only those listed are asserted.
//  FETCH: mem_req=1. On mem_rdy=1: ir_load=1, pc_write=1, pc_sel=0, -> DECODE. Else stay, wait_cnt++.
//  DECODE: if opcode==HLT -> HALT. Branch taken t:
//   BRA/BRR: t = (mm==0) | |(stat & mm);  BNE/BNR: t = (mm==0) | ~|(stat & mm).
//   br_sel=1 for BRA/BNE (absolute), 0 for BRR/BNR (relative); if t: pc_sel=1, pc_write=1.
//   Non-branch or untaken: pc_write=0. -> EXECUTE.
//  EXECUTE: alu_op = 1 (REG_OP), 3 (REG_IM), else 0. -> MEM.
//  MEM: REG_OP alu_op=0, REG_IM alu_op=2. LDA/LDX/STA/STX: mem_req=1; STA/STX also mem_we=1;
//   LDX/STX rb_sel=1. Leave on mem_rdy=1 (or immediately for non-memory opcodes) -> WRITEBACK.
//  WRITEBACK: REG_OP/REG_IM: rf_we=1, wb_sel=0. LDA/LDX: rf_we=1, wb_sel=1 (LDX rb_sel=1).
//   Others: nothing. -> FETCH (or IDLE, see CONFIGURATION).
//  HALT: halted=1, all strobes 0; exits only via rst_f.
//  Latency: 5 cycles/instruction with zero wait states; +1 per cycle mem_rdy low in FETCH or MEM.
//  Timeout: wait_cnt clears on entering FETCH/MEM; if wait_cnt==WAIT_MAX and mem_rdy=0 ->
//   mem_err<=1, -> HALT. mem_rdy=1 on the same cycle as the limit wins (normal completion).
//  mem_we held for the whole MEM wait; memory commits on mem_rdy cycle only.
//  rst_f mid-operation: state->START asynchronously; mem_req/mem_we/rf_we drop same instant.
//  opcode/mm/stat must be stable from DECODE through WRITEBACK (IR not reloaded until FETCH).
// CONFIGURATION
//  SISC_CTRL_STEP_EN defined: extra input step (1 bit); WRITEBACK -> IDLE; IDLE holds all strobes 0
//   and goes -> FETCH on the first cycle step=1 (one instruction per step pulse).
//  Undefined: no step port; WRITEBACK -> FETCH directly; IDLE unreachable (decodes -> START).
// TESTING
//  Reset release, mem_rdy=1 tied -> START(pc_rst=pc_write=1) then FETCH with ir_load=1 one cycle later.
//  REG_IM, zero waits -> alu_op 3 in EXECUTE, 2 in MEM, rf_we=1 wb_sel=0 in WRITEBACK; 5 cycles.
//  BNE mm=1 stat=0 -> DECODE br_sel=1 pc_sel=1 pc_write=1; stat=1 -> pc_write=0 pc_sel=0.
//  STX, mem_rdy low 3 cycles -> mem_req=mem_we=rb_sel=1 for 4 MEM cycles, rf_we=0 in WRITEBACK.
//  LDA, mem_rdy never high, WAIT_MAX=15 -> mem_err=1, halted=1 after 16 MEM cycles; rst_f clears both.
//  HLT -> halted=1 cycle after DECODE, strobes 0 for 20 cycles; STEP_EN: no FETCH until step=1.

Source files
------------

// File: rtl/sisc_ctrl_ws.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_ws
//   Multicycle SISC control FSM with a memory wait-state handshake, masked
//   branch conditions, a sticky memory-timeout error and a terminal HALT
//   state. Drives the datapath strobes (PC, RF, ALU, IR, data memory) as a
//   combinational decode of the present state plus the IR/status inputs.
//
//   Optional feature macro: SISC_CTRL_STEP_EN
//     defined   -> extra input 'step'; after WRITEBACK the FSM parks in IDLE
//                  and fetches the next instruction on the first step=1.
//     undefined -> WRITEBACK goes straight back to FETCH; IDLE is unused.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_f      in   1     asynchronous active-low reset
//   opcode     in   OPW   IR opcode
//   mm         in   OPW   IR condition mask
//   stat       in   CCW   status register condition codes (stat[0] = Z)
//   mem_rdy    in   1     memory completes the current request this cycle
//   step       in   1     single-step pulse (SISC_CTRL_STEP_EN only)
//   rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load, mem_we,
//   rb_sel     out  1     datapath strobes
//   alu_op     out  ALUW  ALU function select
//   mem_req    out  1     memory request (instruction in FETCH, data in MEM)
//   halted     out  1     FSM is in HALT
//   mem_err    out  1     sticky memory-timeout flag
//   state      out  4     present state encoding (debug)
// -----------------------------------------------------------------------------
module sisc_ctrl_ws #(
  parameter int OPW      = 4,
  parameter int CCW      = 4,
  parameter int ALUW     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  mm,
  input  logic [CCW-1:0]  stat,
  input  logic            mem_rdy,
`ifdef SISC_CTRL_STEP_EN
  input  logic            step,
`endif
  output logic            rf_we,
  output logic            wb_sel,
  output logic            br_sel,
  output logic            pc_rst,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            ir_load,
  output logic            mem_we,
  output logic            rb_sel,
  output logic [ALUW-1:0] alu_op,
  output logic            mem_req,
  output logic            halted,
  output logic            mem_err,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXECUTE   = 4'd3,
    ST_MEM       = 4'd4,
    ST_WRITEBACK = 4'd5,
    ST_HALT      = 4'd6,
    ST_IDLE      = 4'd7
  } state_t;

  // Opcode map (NOOP = 0 needs no constant: it falls into every default).
  localparam logic [OPW-1:0] OP_REG_OP = OPW'(1);
  localparam logic [OPW-1:0] OP_REG_IM = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA    = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR    = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE    = OPW'(6);
  localparam logic [OPW-1:0] OP_BNR    = OPW'(7);
  localparam logic [OPW-1:0] OP_LDA    = OPW'(10);
  localparam logic [OPW-1:0] OP_LDX    = OPW'(11);
  localparam logic [OPW-1:0] OP_STA    = OPW'(12);
  localparam logic [OPW-1:0] OP_STX    = OPW'(13);
  localparam logic [OPW-1:0] OP_HLT    = OPW'(15);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  // Only the overlapping bits of mask and status take part in a branch test.
  localparam int MW = (OPW < CCW) ? OPW : CCW;

  state_t         state_reg, state_next;
  logic [7:0]     wait_cnt_reg, wait_cnt_next;
  logic           mem_err_reg, mem_err_next;
  logic [MW-1:0]  cc_hit;
  logic           any_hit;
  logic           mm_zero;
  logic           is_load, is_store, is_indexed, is_mem;

  genvar gi;
  generate
    for (gi = 0; gi < MW; gi++) begin : g_cc_hit
      assign cc_hit[gi] = stat[gi] & mm[gi];
    end
  endgenerate

  assign any_hit    = |cc_hit;
  assign mm_zero    = (mm == '0);
  assign is_load    = (opcode == OP_LDA) || (opcode == OP_LDX);
  assign is_store   = (opcode == OP_STA) || (opcode == OP_STX);
  assign is_indexed = (opcode == OP_LDX) || (opcode == OP_STX);
  assign is_mem     = is_load || is_store;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= ST_START;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  // wait_cnt_next defaults to zero, so any state that leaves FETCH/MEM (or
  // enters them from elsewhere) starts the next wait window from zero; it
  // only advances while a memory access is stalled.
  always_comb begin
    state_next    = ST_START;
    wait_cnt_next = '0;
    mem_err_next  = mem_err_reg;
    rf_we         = 1'b0;
    wb_sel        = 1'b0;
    br_sel        = 1'b0;
    pc_rst        = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ir_load       = 1'b0;
    mem_we        = 1'b0;
    rb_sel        = 1'b0;
    alu_op        = '0;
    mem_req       = 1'b0;
    halted        = 1'b0;

    case (state_reg)
      ST_START: begin
        pc_rst     = 1'b1;
        pc_write   = 1'b1;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_cnt_reg == WAIT_LIM) begin
          mem_err_next = 1'b1;
          state_next   = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          state_next    = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXECUTE;
          if ((opcode == OP_BRA) || (opcode == OP_BRR)) begin
            br_sel = (opcode == OP_BRA);
            if (mm_zero || any_hit) begin
              pc_sel   = 1'b1;
              pc_write = 1'b1;
            end
          end else if ((opcode == OP_BNE) || (opcode == OP_BNR)) begin
            br_sel = (opcode == OP_BNE);
            if (mm_zero || !any_hit) begin
              pc_sel   = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
      end

      ST_EXECUTE: begin
        if (opcode == OP_REG_OP)      alu_op = ALUW'(1);
        else if (opcode == OP_REG_IM) alu_op = ALUW'(3);
        state_next = ST_MEM;
      end

      ST_MEM: begin
        if (opcode == OP_REG_IM) alu_op = ALUW'(2);
        if (is_mem) begin
          // Request and write enable stay up for the whole stall; the
          // memory only commits on the cycle it raises mem_rdy.
          mem_req = 1'b1;
          mem_we  = is_store;
          rb_sel  = is_indexed;
          if (mem_rdy) begin
            state_next = ST_WRITEBACK;
          end else if (wait_cnt_reg == WAIT_LIM) begin
            mem_err_next = 1'b1;
            state_next   = ST_HALT;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
            state_next    = ST_MEM;
          end
        end else begin
          state_next = ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        if ((opcode == OP_REG_OP) || (opcode == OP_REG_IM)) begin
          rf_we = 1'b1;
        end else if (is_load) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
          rb_sel = (opcode == OP_LDX);
        end
`ifdef SISC_CTRL_STEP_EN
        state_next = ST_IDLE;
`else
        state_next = ST_FETCH;
`endif
      end

      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end

`ifdef SISC_CTRL_STEP_EN
      ST_IDLE: begin
        state_next = step ? ST_FETCH : ST_IDLE;
      end
`endif

      default: begin
        state_next = ST_START;
      end
    endcase
  end

  assign mem_err = mem_err_reg;
  assign state   = state_reg;

endmodule
